// File: rtl/multiplexor_display_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multiplexor_display_bcd_pkg
// Description : Shared constants and types for the four-digit BCD counter
//               with multiplexed seven-segment scan.
// Revision    : 1.0 - initial release
// ============================================================================
package multiplexor_display_bcd_pkg;

  // One BCD decade digit, legal values 0..9
  typedef logic [3:0] bcd_t;

  // Packed four-digit count, index 3 = thousands, index 0 = units
  typedef bcd_t [3:0] cuenta_t;

  // Highest legal BCD digit value
  localparam bcd_t BCD_MAX = 4'd9;

  // All digit-select lines inactive (active-low select)
  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage : multiplexor_display_bcd_pkg
`default_nettype wire

// File: rtl/multiplexor_display_bcd_digito.sv
`default_nettype none
// ============================================================================
// Module      : contador_bcd_digito
// Description : One decade of a BCD counter. Increments on carry-in, wraps
//               9 -> 0 and raises carry-out in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_bcd_digito
  import multiplexor_display_bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cin,
  output bcd_t valor,
  output logic cout
);

  bcd_t r_valor;

  // Decade register: reset and clear win over carry-in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valor <= '0;
    end else if (clr) begin
      r_valor <= '0;
    end else if (cin) begin
      r_valor <= (r_valor == BCD_MAX) ? bcd_t'(4'd0) : r_valor + 4'd1;
    end
  end

  // Ripple carry into the next decade happens in the same cycle
  assign cout  = (r_valor == BCD_MAX) && cin;
  assign valor = r_valor;

endmodule : contador_bcd_digito
`default_nettype wire

// File: rtl/multiplexor_display_bcd.sv
`default_nettype none
// ============================================================================
// Module      : multiplexor_display_bcd
// Description : Four-digit BCD event counter (0000..9999, wrapping) with a
//               time-multiplexed scan driving one shared BCD-to-7-segment
//               decoder and active-low digit selects, leading-zero blanked.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplexor_display_bcd
  import multiplexor_display_bcd_pkg::*;
#(
  parameter int PRESC = 50000
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] cuenta,
  output logic [3:0]  digito,
  output logic [3:0]  an,
  output logic        desborde
);

  // Prescaler width; kept at least one bit so PRESC=1 still elaborates
  localparam int c_presc_w = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [c_presc_w-1:0] c_presc_tc = c_presc_w'(PRESC - 1);

  cuenta_t              w_cuenta;
  logic [4:0]           w_carry;
  logic [3:0]           w_zero;
  logic [3:0]           w_blank;
  logic [3:0]           w_sel;
  logic                 w_tc;

  logic [c_presc_w-1:0] r_presc;
  logic [1:0]           r_idx;
  bcd_t                 r_digito;
  logic [3:0]           r_an;
  logic                 r_desborde;

  // Units digit counts on inc; each higher digit counts on the carry below it
  assign w_carry[0] = inc;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_digito
      contador_bcd_digito u_digito (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .cin   (w_carry[k]),
        .valor (w_cuenta[k]),
        .cout  (w_carry[k+1])
      );
    end
  endgenerate

  // Wrap flag: carry out of thousands means 9999 -> 0000 this edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_desborde <= 1'b0;
    end else if (clr) begin
      r_desborde <= 1'b0;
    end else begin
      r_desborde <= w_carry[4];
    end
  end

  // Leading-zero detection: a digit is blank only if it and all above are 0;
  // the units digit always shows so an all-zero count reads "0"
  assign w_zero[0] = (w_cuenta[0] == 4'd0);
  assign w_zero[1] = (w_cuenta[1] == 4'd0);
  assign w_zero[2] = (w_cuenta[2] == 4'd0);
  assign w_zero[3] = (w_cuenta[3] == 4'd0);

  assign w_blank[3] = w_zero[3];
  assign w_blank[2] = w_zero[3] & w_zero[2];
  assign w_blank[1] = w_zero[3] & w_zero[2] & w_zero[1];
  assign w_blank[0] = 1'b0;

  assign w_tc  = (r_presc == c_presc_tc);
  assign w_sel = 4'b0001 << r_idx;

  // Prescaler and scan index: one slot per PRESC cycles, reset restarts slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (w_tc) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Display outputs registered from the live count, so count changes and
  // blanking changes show on the next edge without waiting for slot end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digito <= 4'h0;
      r_an     <= 4'b1110;
    end else begin
      r_digito <= w_cuenta[r_idx];
      r_an     <= w_blank[r_idx] ? AN_OFF : ~w_sel;
    end
  end

  assign cuenta   = w_cuenta;
  assign digito   = r_digito;
  assign an       = r_an;
  assign desborde = r_desborde;

endmodule : multiplexor_display_bcd
`default_nettype wire

// File: tb/tb_multiplexor_display_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplexor_display_bcd
// Description : Scoreboard bench for multiplexor_display_bcd with PRESC=4.
//               Stimulus queues expected outputs; a negedge monitor pops and
//               compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplexor_display_bcd;

  localparam int PRESC = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc   = 1'b0;
  logic        clr   = 1'b0;
  logic [15:0] cuenta;
  logic [3:0]  digito;
  logic [3:0]  an;
  logic        desborde;

  multiplexor_display_bcd #(.PRESC(PRESC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc),
    .clr      (clr),
    .cuenta   (cuenta),
    .digito   (digito),
    .an       (an),
    .desborde (desborde)
  );

  always #5 clk = ~clk;

  // mask bits: [0] cuenta, [1] an, [2] digito, [3] desborde
  typedef struct {
    bit [95:0]   name;
    bit [3:0]    mask;
    logic [15:0] cuenta;
    logic [3:0]  an;
    logic [3:0]  digito;
    logic        desborde;
    bit          timeout;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit [95:0] nm, input bit [3:0] m, input logic [15:0] c,
                      input logic [3:0] a, input logic [3:0] d, input logic o);
    exp_t e;
    e.name = nm; e.mask = m; e.cuenta = c; e.an = a; e.digito = d;
    e.desborde = o; e.timeout = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_timeout(input bit [95:0] nm);
    exp_t e;
    e.name = nm; e.mask = 4'b0000; e.cuenta = '0; e.an = '0; e.digito = '0;
    e.desborde = 1'b0; e.timeout = 1'b1;
    q.push_back(e);
  endtask

  // Align to the first cycle in which the units slot is shown
  task automatic sync_slot0(input bit [95:0] nm);
    int n = 0;
    while (an == 4'b1110 && n < 64) begin tick(); n++; end
    while (an != 4'b1110 && n < 64) begin tick(); n++; end
    if (n >= 64) push_timeout(nm);
  endtask

  // One full frame: slot s expects ans[4s+:4] / digs[4s+:4] for PRESC cycles
  task automatic scan_check(input bit [95:0] nm, input logic [15:0] ans,
                            input logic [15:0] digs, input logic [15:0] c);
    sync_slot0(nm);
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < PRESC; k++) begin
        push(nm, 4'b1111, c, ans[s*4 +: 4], digs[s*4 +: 4], 1'b0);
        tick();
      end
    end
  endtask

  // Monitor: every negedge, compare all expectations queued for this cycle
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (e.timeout) begin
        bad++;
        $display("FAIL %s: scan sync wait expired, an=%b required transition to 1110", e.name, an);
      end else if ((e.mask[0] && cuenta   !== e.cuenta) ||
                   (e.mask[1] && an       !== e.an)     ||
                   (e.mask[2] && digito   !== e.digito) ||
                   (e.mask[3] && desborde !== e.desborde)) begin
        bad++;
        $display("FAIL %s: got cuenta=%h an=%b digito=%h desborde=%b; want cuenta=%h an=%b digito=%h desborde=%b (mask %b)",
                 e.name, cuenta, an, digito, desborde,
                 e.cuenta, e.an, e.digito, e.desborde, e.mask);
      end
    end
  end

  initial begin
    // Reset held with inc high: everything stays at reset values
    rst_n = 1'b0; inc = 1'b1; clr = 1'b0;
    repeat (3) begin
      tick();
      push("rst_hold", 4'b1111, 16'h0000, 4'b1110, 4'h0, 1'b0);
    end
    rst_n = 1'b1; inc = 1'b0;
    scan_check("rst_walk", 16'hFFFE, 16'h0000, 16'h0000);

    // Ripple to 1234
    inc = 1'b1; repeat (1234) tick(); inc = 1'b0;
    push("ripple", 4'b1001, 16'h1234, 4'h0, 4'h0, 1'b0);
    scan_check("scan1234", 16'h7BDE, 16'h1234, 16'h1234);

    // Clear, count to 9999, then wrap
    clr = 1'b1; tick(); clr = 1'b0;
    push("clr", 4'b1001, 16'h0000, 4'h0, 4'h0, 1'b0);
    inc = 1'b1; repeat (9999) tick(); inc = 1'b0;
    push("pre_wrap", 4'b1001, 16'h9999, 4'h0, 4'h0, 1'b0);
    inc = 1'b1; tick(); inc = 1'b0;
    push("wrap", 4'b1001, 16'h0000, 4'h0, 4'h0, 1'b1);
    tick();
    push("wrap_end", 4'b1001, 16'h0000, 4'h0, 4'h0, 1'b0);
    scan_check("scan_wrap", 16'hFFFE, 16'h0000, 16'h0000);

    // Clear has priority over inc
    inc = 1'b1; repeat (57) tick(); inc = 1'b0;
    push("cnt57", 4'b1001, 16'h0057, 4'h0, 4'h0, 1'b0);
    clr = 1'b1; inc = 1'b1; tick(); clr = 1'b0; inc = 1'b0;
    push("clr_prio", 4'b1001, 16'h0000, 4'h0, 4'h0, 1'b0);
    tick();
    push("clr_prio2", 4'b1001, 16'h0000, 4'h0, 4'h0, 1'b0);

    // Blanking edge at 0100: tens zero shown, thousands blanked
    inc = 1'b1; repeat (100) tick(); inc = 1'b0;
    push("cnt100", 4'b1001, 16'h0100, 4'h0, 4'h0, 1'b0);
    scan_check("scan0100", 16'hFBDE, 16'h0100, 16'h0100);

    // Mid-slot reset at prescaler 2, idx 2
    sync_slot0("mid_sync");
    repeat (9) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    push("mid_rst", 4'b1111, 16'h0000, 4'b1110, 4'h0, 1'b0);
    repeat (4) begin
      tick();
      push("mid_slot0", 4'b0110, 16'h0000, 4'b1110, 4'h0, 1'b0);
    end
    tick();
    push("mid_slot1", 4'b0110, 16'h0000, 4'b1111, 4'h0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multiplexor_display_bcd
`default_nettype wire
